// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: sequential step, branch/jump
// redirects, stall hold with a single latched pending redirect, trap entry to
// a fixed vector with exception-PC capture, and trap return.
module pc_gen #(
  parameter int                PCLEN      = 16,
  parameter logic [PCLEN-1:0] RESET_ADDR = '0,
  parameter logic [PCLEN-1:0] TRAP_VEC   = {{(PCLEN-4){1'b1}}, 4'b0000}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       pcsel,
  input  logic [PCLEN-1:0] targaddr,
  input  logic             trap,
  input  logic             eret,
  output logic [PCLEN-1:0] pcOut,
  output logic [PCLEN-1:0] pcplus4,
  output logic [PCLEN-1:0] epc,
  output logic             pend_valid
);

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_JALR = 2'b01;
  localparam logic [1:0] SEL_BR   = 2'b10;
  localparam logic [1:0] SEL_JAL  = 2'b11;

  logic [PCLEN-1:0] target;
  logic [PCLEN-1:0] pend_target;
  logic             redirect;

  // Word-address addition; carry out is dropped so the PC wraps silently.
  function automatic logic [PCLEN-1:0] wrap_add(input logic [PCLEN-1:0] a,
                                                input logic [PCLEN-1:0] b);
    wrap_add = a + b;
  endfunction

  assign redirect = (pcsel != SEL_SEQ);

  // Next-PC candidate selected by pcsel from the current fetch PC.
  always_comb begin
    target = wrap_add(pcOut, PCLEN'(1));
    case (pcsel)
      SEL_SEQ:  target = wrap_add(pcOut, PCLEN'(1));
      SEL_JALR: target = targaddr;
      SEL_BR:   target = wrap_add(pcOut, targaddr);
      SEL_JAL:  target = wrap_add(pcOut, targaddr);
      default:  target = wrap_add(pcOut, PCLEN'(1));
    endcase
  end

  // Link value is only meaningful for the jump encodings (pcsel[0] set).
  always_comb begin
    pcplus4 = '0;
    if (pcsel[0]) pcplus4 = wrap_add(pcOut, PCLEN'(1));
  end

  // PC, exception PC and pending flag, in priority reset > trap > eret >
  // pending release > stall > normal step.
  always_ff @(posedge clock) begin
    if (reset) begin
      pcOut      <= RESET_ADDR;
      epc        <= '0;
      pend_valid <= 1'b0;
    end else if (trap) begin
      epc        <= pcOut;
      pcOut      <= TRAP_VEC;
      pend_valid <= 1'b0;
    end else if (eret) begin
      pcOut      <= epc;
      pend_valid <= 1'b0;
    end else if (!stall && pend_valid) begin
      pcOut      <= pend_target;
      pend_valid <= 1'b0;
    end else if (stall) begin
      if (redirect && !pend_valid) pend_valid <= 1'b1;
    end else begin
      pcOut <= target;
    end
  end

  // Pending target is pure data: captured only by the first redirect of a
  // stall and qualified everywhere by pend_valid, so it needs no reset.
  always_ff @(posedge clock) begin
    if (!reset && !trap && !eret && stall && redirect && !pend_valid)
      pend_target <= target;
  end

endmodule
